// File: rtl/cva6_hpicache_req_arbiter.sv
// Shares the HPICache request port between NUM_REQ fetch requesters and the icache flush.
// Round-robin grant, TID stamping, per-requester outstanding tracking and flush sequencing.
module cva6_hpicache_req_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned TID_W     = 3,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload_i,
  input  logic                           flush_i,
  output logic                           flush_ack_o,
  output logic                           cache_req_valid_o,
  input  logic                           cache_req_ready_i,
  output logic [PAYLOAD_W-1:0]           cache_req_o,
  output logic [TID_W-1:0]               cache_req_tid_o,
  output logic                           cache_req_is_flush_o,
  input  logic                           cache_rsp_valid_i,
  input  logic [TID_W-1:0]               cache_rsp_tid_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]                        state_q, state_d;
  logic [PTR_W-1:0]                  ptr_q, ptr_d;
  logic [NUM_REQ-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic                              err_q, err_d;

  logic [NUM_REQ-1:0][PAYLOAD_W-1:0] pay;
  logic [NUM_REQ-1:0]                elig;
  logic [NUM_REQ-1:0]                dec;
  logic                              win_found;
  logic [PTR_W-1:0]                  win_idx;
  logic                              hs;
  int unsigned                       scan;

  assign pay = req_payload_i;

  // Round-robin search starting at the pointer; outputs are gated while in reset
  always_comb begin
    elig      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i] = rst_ni & req_valid_i[i] & (cnt_q[i] < CNT_W'(MAX_OUTST)) & (state_q == S_IDLE);
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = 32'(ptr_q) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!win_found && elig[PTR_W'(scan)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(scan);
      end
    end
  end

  always_comb begin
    req_ready_o          = '0;
    cache_req_valid_o    = win_found | (rst_ni & (state_q == S_ISSUE));
    cache_req_is_flush_o = rst_ni & (state_q == S_ISSUE);
    cache_req_tid_o      = '0;
    cache_req_o          = '0;
    hs                   = win_found & cache_req_ready_i;
    if (win_found) begin
      req_ready_o[win_idx] = cache_req_ready_i;
      cache_req_tid_o      = TID_W'(32'(win_idx) + 1);
      cache_req_o          = pay[win_idx];
    end
  end

  // Response routing by TID; TID 0 is only legal as the flush completion
  always_comb begin
    rsp_valid_o = '0;
    flush_ack_o = 1'b0;
    dec         = '0;
    err_d       = err_q;
    if (rst_ni && cache_rsp_valid_i) begin
      if (cache_rsp_tid_i == '0) begin
        if (state_q == S_WAIT) flush_ack_o = 1'b1;
        else                   err_d       = 1'b1;
      end else if (cache_rsp_tid_i > TID_W'(NUM_REQ)) begin
        err_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (cache_rsp_tid_i == TID_W'(i + 1)) begin
            if (cnt_q[i] != '0) begin
              rsp_valid_o[i] = 1'b1;
              dec[i]         = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        if (state_q == S_WAIT) err_d = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (hs && (win_idx == PTR_W'(i)) && !dec[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (!(hs && (win_idx == PTR_W'(i))) && dec[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
    if (hs) begin
      if (32'(win_idx) == NUM_REQ - 1) ptr_d = '0;
      else                             ptr_d = win_idx + PTR_W'(1);
    end
  end

  // Flush sequencing: drain, issue, wait for TID 0
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (flush_i)           state_d = S_DRAIN;
      S_DRAIN: if (cnt_q == '0)       state_d = S_ISSUE;
      S_ISSUE: if (cache_req_ready_i) state_d = S_WAIT;
      S_WAIT:  if (flush_ack_o)       state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  assign busy_o = (cnt_q != '0) | (state_q != S_IDLE);
  assign err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_cva6_hpicache_req_arbiter.sv
// Self-checking bench for cva6_hpicache_req_arbiter against a queue-based reference model.
module tb_cva6_hpicache_req_arbiter;
  localparam int unsigned NR = 3;
  localparam int unsigned PW = 128;
  localparam int unsigned TW = 3;
  localparam int unsigned MO = 4;
  localparam int unsigned OW = 14 + PW;

  logic                   clk = 1'b0;
  logic                   rst_ni = 1'b0;
  logic [NR-1:0]          req_valid = '0;
  logic [NR-1:0]          req_ready_o;
  logic [NR-1:0][PW-1:0]  pay = '0;
  logic                   flush = 1'b0;
  logic                   flush_ack_o;
  logic                   cache_req_valid_o;
  logic                   cready = 1'b0;
  logic [PW-1:0]          cache_req_o;
  logic [TW-1:0]          cache_req_tid_o;
  logic                   cache_req_is_flush_o;
  logic                   rvalid = 1'b0;
  logic [TW-1:0]          rtid = '0;
  logic [NR-1:0]          rsp_valid_o;
  logic                   busy_o;
  logic                   err_o;

  int n_cmp = 0;
  int n_fail = 0;

  cva6_hpicache_req_arbiter #(.NUM_REQ(NR), .PAYLOAD_W(PW), .TID_W(TW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_payload_i(pay), .flush_i(flush), .flush_ack_o(flush_ack_o),
    .cache_req_valid_o(cache_req_valid_o), .cache_req_ready_i(cready), .cache_req_o(cache_req_o),
    .cache_req_tid_o(cache_req_tid_o), .cache_req_is_flush_o(cache_req_is_flush_o),
    .cache_rsp_valid_i(rvalid), .cache_rsp_tid_i(rtid), .rsp_valid_o(rsp_valid_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Reference model: pointer, list of outstanding TIDs, flush phase (0 idle,1 drain,2 issue,3 wait)
  int            m_ptr = 0;
  int            m_fsm = 0;
  int            m_out[$];
  bit            m_err = 1'b0;
  logic [OW-1:0] e_vec;
  logic [NR-1:0] e_ready, e_rsp;
  int            e_win, e_hs_tid, e_rm_tid, e_nfsm;
  bit            e_err_set, e_ack;

  function automatic logic [PW-1:0] rnd_pay();
    return PW'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [OW-1:0] obs();
    return {cache_req_valid_o, cache_req_is_flush_o, cache_req_tid_o, req_ready_o,
            rsp_valid_o, flush_ack_o, busy_o, err_o, cache_req_o};
  endfunction

  function automatic int count_of(int idx);
    int c = 0;
    foreach (m_out[j]) if (m_out[j] == idx + 1) c++;
    return c;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_fsm = 0; m_err = 1'b0; m_out.delete();
  endtask

  task automatic model_eval();
    int t, j;
    logic [PW-1:0] ep;
    logic [TW-1:0] et;
    e_win = -1;
    if (m_fsm == 0)
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (e_win < 0 && req_valid[j] && count_of(j) < MO) e_win = j;
      end
    e_ready = (e_win >= 0 && cready) ? (NR'(1) << e_win) : '0;
    e_hs_tid = (e_win >= 0 && cready) ? e_win + 1 : 0;
    e_rsp = '0; e_ack = 1'b0; e_err_set = 1'b0; e_rm_tid = 0;
    if (rvalid) begin
      t = int'(rtid);
      if (t == 0) begin
        if (m_fsm == 3) e_ack = 1'b1; else e_err_set = 1'b1;
      end else if (t <= NR) begin
        if (count_of(t - 1) > 0) begin e_rsp[t-1] = 1'b1; e_rm_tid = t; end
        else e_err_set = 1'b1;
        if (m_fsm == 3) e_err_set = 1'b1;
      end else e_err_set = 1'b1;
    end
    case (m_fsm)
      0:       e_nfsm = flush ? 1 : 0;
      1:       e_nfsm = (m_out.size() == 0) ? 2 : 1;
      2:       e_nfsm = cready ? 3 : 2;
      default: e_nfsm = e_ack ? 0 : 3;
    endcase
    ep = (e_win >= 0) ? pay[e_win] : '0;
    et = (e_win >= 0) ? TW'(e_win + 1) : '0;
    e_vec = {(e_win >= 0) || (m_fsm == 2), m_fsm == 2, et, e_ready, e_rsp, e_ack,
             (m_out.size() != 0) || (m_fsm != 0), m_err, ep};
  endtask

  task automatic model_commit();
    if (e_rm_tid != 0)
      for (int j = 0; j < m_out.size(); j++)
        if (m_out[j] == e_rm_tid) begin m_out.delete(j); break; end
    if (e_hs_tid != 0) begin
      m_out.push_back(e_hs_tid);
      m_ptr = (e_win + 1) % NR;
    end
    m_fsm = e_nfsm;
    m_err = m_err | e_err_set;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (obs() !== '0) begin n_fail++; $display("FAIL reset_idle: got %h exp 0", obs()); end
    req_valid = '1; cready = 1'b1; rvalid = 1'b1; rtid = TW'(1); pay[0] = rnd_pay();
    #2;
    n_cmp++;
    if (obs() !== '0) begin n_fail++; $display("FAIL reset_gated: got %h exp 0", obs()); end
    req_valid = '0; cready = 1'b0; rvalid = 1'b0; rtid = '0;
    @(negedge clk); rst_ni = 1'b1; model_reset();
    @(posedge clk); #1;
    model_eval(); @(negedge clk);
    n_cmp++;
    if (obs() !== e_vec) begin n_fail++; $display("FAIL reset_release: got %h exp %h", obs(), e_vec); end
    @(posedge clk); model_commit(); #1;
  endtask

  task automatic test_round_robin();
    int prev = 0;
    req_valid = '1; cready = 1'b1;
    for (int i = 0; i < NR; i++) pay[i] = rnd_pay();
    for (int k = 0; k < 7; k++) begin
      if (k == 6) req_valid = '0;
      rvalid = (k > 0); rtid = TW'(prev);
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL rr_model k=%0d: got %h exp %h", k, obs(), e_vec); end
      if (k < 6) begin
        n_cmp++;
        if (req_ready_o !== (3'b001 << (k % 3)) || cache_req_tid_o !== TW'(k % 3 + 1) ||
            rsp_valid_o !== ((k > 0) ? (3'b001 << ((k - 1) % 3)) : 3'b000)) begin
          n_fail++;
          $display("FAIL rr_seq k=%0d: got rdy=%b tid=%0d rsp=%b", k, req_ready_o, cache_req_tid_o, rsp_valid_o);
        end
      end
      @(posedge clk); model_commit(); #1;
      prev = k % 3 + 1;
      if (k < 6) pay[k % 3] = rnd_pay();
    end
    rvalid = 1'b0;
  endtask

  task automatic test_max_outst();
    int grants = 0;
    int more = 0;
    req_valid = 3'b001; cready = 1'b1; rvalid = 1'b0; pay[0] = rnd_pay();
    for (int k = 0; k < 6; k++) begin
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL maxo_model k=%0d: got %h exp %h", k, obs(), e_vec); end
      if (req_ready_o[0]) grants++;
      @(posedge clk); model_commit(); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (grants != 4 || req_ready_o[0] !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL maxo_limit: got grants=%0d rdy0=%b busy=%b exp 4/0/1", grants, req_ready_o[0], busy_o);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      rvalid = (k == 0); rtid = TW'(1);
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL maxo_refill k=%0d: got %h exp %h", k, obs(), e_vec); end
      if (req_ready_o[0]) more++;
      @(posedge clk); model_commit(); #1;
    end
    n_cmp++;
    if (more != 1) begin n_fail++; $display("FAIL maxo_one_more: got %0d exp 1", more); end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; rtid = TW'(1);
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL maxo_drain k=%0d: got %h exp %h", k, obs(), e_vec); end
      @(posedge clk); model_commit(); #1;
    end
    rvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    req_valid = 3'b110; cready = 1'b0; pay[1] = rnd_pay(); pay[2] = rnd_pay();
    for (int k = 0; k < 7; k++) begin
      if (k == 5) cready = 1'b1;
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL bp_model k=%0d: got %h exp %h", k, obs(), e_vec); end
      n_cmp++;
      if (k < 5 && (cache_req_o !== pay[1] || cache_req_tid_o !== TW'(2) || req_ready_o !== 3'b000)) begin
        n_fail++; $display("FAIL bp_hold k=%0d: got tid=%0d rdy=%b", k, cache_req_tid_o, req_ready_o);
      end else if (k == 5 && req_ready_o !== 3'b010) begin
        n_fail++; $display("FAIL bp_grant: got %b exp 010", req_ready_o);
      end else if (k == 6 && req_ready_o !== 3'b100) begin
        n_fail++; $display("FAIL bp_pointer: got %b exp 100", req_ready_o);
      end
      @(posedge clk); model_commit(); #1;
      if (k == 5) pay[1] = rnd_pay();
    end
    req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      rvalid = 1'b1; rtid = TW'(k + 2);
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL bp_drain k=%0d: got %h exp %h", k, obs(), e_vec); end
      @(posedge clk); model_commit(); #1;
    end
    rvalid = 1'b0;
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    req_valid = 3'b011; cready = 1'b1; pay[0] = rnd_pay(); pay[1] = rnd_pay();
    for (int k = 0; k < 2; k++) begin
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL fl_pre k=%0d: got %h exp %h", k, obs(), e_vec); end
      @(posedge clk); model_commit(); #1;
      if (k == 0) req_valid = 3'b010;
    end
    req_valid = '0; flush = 1'b1;
    model_eval(); @(negedge clk);
    n_cmp++;
    if (obs() !== e_vec) begin n_fail++; $display("FAIL fl_raise: got %h exp %h", obs(), e_vec); end
    @(posedge clk); model_commit(); #1;
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      rvalid = (k >= 3); rtid = TW'(k - 2);
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL fl_drain k=%0d: got %h exp %h", k, obs(), e_vec); end
      n_cmp++;
      if (cache_req_valid_o !== 1'b0 || req_ready_o !== 3'b000) begin
        n_fail++; $display("FAIL fl_no_grant k=%0d: got valid=%b rdy=%b", k, cache_req_valid_o, req_ready_o);
      end
      @(posedge clk); model_commit(); #1;
    end
    rvalid = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL fl_issue k=%0d: got %h exp %h", k, obs(), e_vec); end
      if (cache_req_is_flush_o === 1'b1) begin
        seen = 1'b1;
        n_cmp++;
        if (cache_req_valid_o !== 1'b1 || cache_req_tid_o !== '0 || cache_req_o !== '0 || req_ready_o !== '0) begin
          n_fail++; $display("FAIL fl_cmd: got valid=%b tid=%0d pay=%h", cache_req_valid_o, cache_req_tid_o, cache_req_o);
        end
      end
      @(posedge clk); model_commit(); #1;
    end
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL fl_timeout: got no flush issue exp one within 4 cycles"); end
    for (int k = 0; k < 3; k++) begin
      rvalid = (k == 1); rtid = '0;
      if (k == 2) flush = 1'b0;
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL fl_wait k=%0d: got %h exp %h", k, obs(), e_vec); end
      n_cmp++;
      if (flush_ack_o !== (k == 1) || (k == 2 && req_ready_o !== 3'b100)) begin
        n_fail++; $display("FAIL fl_ack k=%0d: got ack=%b rdy=%b", k, flush_ack_o, req_ready_o);
      end
      @(posedge clk); model_commit(); #1;
    end
    req_valid = '0;
    rvalid = 1'b1; rtid = TW'(3);
    model_eval(); @(negedge clk);
    n_cmp++;
    if (obs() !== e_vec) begin n_fail++; $display("FAIL fl_post: got %h exp %h", obs(), e_vec); end
    @(posedge clk); model_commit(); #1;
    rvalid = 1'b0;
  endtask

  task automatic test_random();
    bit done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      cready = ($urandom_range(3, 0) != 0);
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin req_valid[i] = 1'b1; pay[i] = rnd_pay(); end
      rvalid = 1'b0; rtid = '0;
      if (m_fsm == 3 && $urandom_range(2, 0) == 0) rvalid = 1'b1;
      else if (m_out.size() > 0 && $urandom_range(1, 0) == 1) begin
        rvalid = 1'b1; rtid = TW'(m_out[$urandom_range(m_out.size() - 1, 0)]);
      end
      if (m_fsm == 0 && !flush && $urandom_range(24, 0) == 0) flush = 1'b1;
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL rand c=%0d: got %h exp %h", c, obs(), e_vec); end
      @(posedge clk); model_commit(); #1;
      if (e_ack) flush = 1'b0;
      for (int i = 0; i < NR; i++)
        if (e_ready[i]) begin req_valid[i] = 1'($urandom_range(1, 0)); pay[i] = rnd_pay(); end
    end
    for (int c = 0; c < 80 && !done; c++) begin
      req_valid = '0; cready = 1'b1; rvalid = 1'b0; rtid = '0;
      if (m_fsm == 0 && m_out.size() == 0) done = 1'b1;
      else begin
        if (m_fsm == 3) rvalid = 1'b1;
        else if (m_out.size() > 0) begin rvalid = 1'b1; rtid = TW'(m_out[0]); end
        model_eval(); @(negedge clk);
        n_cmp++;
        if (obs() !== e_vec) begin n_fail++; $display("FAIL rand_drain c=%0d: got %h exp %h", c, obs(), e_vec); end
        @(posedge clk); model_commit(); #1;
        if (e_ack) flush = 1'b0;
      end
    end
    rvalid = 1'b0;
    n_cmp++;
    if (!done) begin n_fail++; $display("FAIL rand_drain_timeout: got fsm=%0d outst=%0d exp idle", m_fsm, m_out.size()); end
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL rand_end: got busy=%b err=%b exp 0/0", busy_o, err_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    req_valid = '0; cready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rvalid = (k < 3);
      rtid = (k == 0) ? TW'(5) : (k == 1) ? TW'(0) : TW'(2);
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL err_model k=%0d: got %h exp %h", k, obs(), e_vec); end
      n_cmp++;
      if (rsp_valid_o !== '0 || err_o !== (k > 0)) begin
        n_fail++; $display("FAIL err_sticky k=%0d: got rsp=%b err=%b", k, rsp_valid_o, err_o);
      end
      @(posedge clk); model_commit(); #1;
    end
    rvalid = 1'b0;
  endtask

  task automatic test_async_reset();
    req_valid = '1; cready = 1'b1;
    for (int i = 0; i < NR; i++) pay[i] = rnd_pay();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin req_valid = '0; flush = 1'b1; end
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL ar_pre k=%0d: got %h exp %h", k, obs(), e_vec); end
      @(posedge clk); model_commit(); #1;
    end
    req_valid = '1; flush = 1'b0;
    #2; rst_ni = 1'b0; #1;
    n_cmp++;
    if (obs() !== '0) begin n_fail++; $display("FAIL ar_outputs: got %h exp 0", obs()); end
    model_reset();
    @(negedge clk);
    req_valid = 3'b001; pay[0] = rnd_pay(); rst_ni = 1'b1; #1;
    model_eval();
    n_cmp++;
    if (obs() !== e_vec || cache_req_tid_o !== TW'(1) || req_ready_o !== 3'b001 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL ar_fresh: got %h exp %h", obs(), e_vec);
    end
    @(posedge clk); model_commit(); #1;
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      rvalid = (k < 2); rtid = (k == 0) ? TW'(2) : TW'(1);
      model_eval(); @(negedge clk);
      n_cmp++;
      if (obs() !== e_vec) begin n_fail++; $display("FAIL ar_post k=%0d: got %h exp %h", k, obs(), e_vec); end
      @(posedge clk); model_commit(); #1;
    end
    rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_max_outst();
    test_backpressure();
    test_flush();
    test_random();
    test_errors();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion exp finish before 500000");
    $fatal(1);
  end

endmodule
